// File: rtl/ame_num_compare_pkg.sv
// ame_num_compare_pkg: shared entry/sideband types and the compare rule for the argmax/argmin tree
package ame_num_compare_pkg;
  localparam int COMP_MAX_BITS = 64;
  localparam int COMP_MAX_IDX_BITS = 8;
  typedef struct packed {
    logic [COMP_MAX_BITS-1:0]     data;
    logic [COMP_MAX_IDX_BITS-1:0] idx;
    logic                         live;
  } comp_entry_t;
  typedef struct packed {
    logic valid;
    logic last;
    logic min;
    logic sgn;
  } comp_side_t;
  function automatic int comp_levels(input int n);
    return $clog2(n);
  endfunction
  // a strictly beats b: live over dead, otherwise strictly better value
  function automatic logic comp_better(input comp_entry_t a, input comp_entry_t b, input logic min, input logic sgn);
    logic gt, lt;
    gt = sgn ? ($signed(a.data) > $signed(b.data)) : (a.data > b.data);
    lt = sgn ? ($signed(a.data) < $signed(b.data)) : (a.data < b.data);
    return a.live && (!b.live || (min ? lt : gt));
  endfunction
endpackage

// File: rtl/ame_num_compare_node.sv
// ame_num_compare_node: registered 2:1 compare node; a holds the lower lanes so ties keep a
module ame_num_compare_node
  import ame_num_compare_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_en,
  input  comp_entry_t i_a,
  input  comp_entry_t i_b,
  input  logic        i_min,
  input  logic        i_signed,
  output comp_entry_t o_q
);
  comp_entry_t w_q, r_q;
  assign w_q = (!i_a.live && !i_b.live) ? '0 : (comp_better(i_b, i_a, i_min, i_signed) ? i_b : i_a);
  assign o_q = r_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_q <= '0;
    else if (i_en) r_q <= w_q;
endmodule

// File: rtl/ame_num_compare_tree.sv
// ame_num_compare_tree: pipelined per-beat compare tree with cross-beat frame accumulator
module ame_num_compare_tree
  import ame_num_compare_pkg::*;
#(
  parameter int COMP_NUM = 6,
  parameter int COMP_DATA_BITS = 64,
  parameter int COMP_DATA_IDX_BITS = $clog2(COMP_NUM),
  parameter int COMP_BEAT_BITS = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               comp_valid_i,
  output logic                               comp_ready_o,
  input  logic                               comp_last_i,
  input  logic                               comp_min_i,
  input  logic                               comp_signed_i,
  input  logic [COMP_NUM-1:0]                comp_mask_i,
  input  logic [COMP_NUM*COMP_DATA_BITS-1:0] comp_data_i,
  output logic                               comp_valid_o,
  input  logic                               comp_ready_i,
  output logic [COMP_DATA_BITS-1:0]          comp_data_o,
  output logic [COMP_DATA_IDX_BITS-1:0]      comp_data_idx_o,
  output logic [COMP_BEAT_BITS-1:0]          comp_beat_idx_o,
  output logic                               comp_none_o
);
  localparam int LEVELS = comp_levels(COMP_NUM);
  localparam int PAD = 1 << LEVELS;
  logic                          w_adv, w_take, w_unused;
  comp_side_t                    w_side [LEVELS+1];
  comp_side_t                    r_side [LEVELS];
  comp_entry_t                   w_leaf [PAD];
  comp_entry_t                   w_node [1:PAD-1];
  comp_entry_t                   w_t, w_m, r_acc;
  logic                          r_active, r_valid, r_none;
  logic [COMP_BEAT_BITS-1:0]     w_cur_beat, w_m_beat, r_acc_beat, r_cnt, r_beat;
  logic [COMP_DATA_BITS-1:0]     r_data;
  logic [COMP_DATA_IDX_BITS-1:0] r_idx;
  assign w_adv = !r_valid | comp_ready_i;
  assign comp_ready_o = w_adv;
  assign comp_valid_o = r_valid;
  assign comp_data_o = r_data;
  assign comp_data_idx_o = r_idx;
  assign comp_beat_idx_o = r_beat;
  assign comp_none_o = r_none;
  // lanes are widened in the beat's own signedness so one 64-bit compare serves both modes
  for (genvar g = 0; g < PAD; g++) begin : g_leaf
    if (g < COMP_NUM) begin : g_lane
      logic [COMP_DATA_BITS-1:0] w_d;
      assign w_d = comp_data_i[g*COMP_DATA_BITS +: COMP_DATA_BITS];
      assign w_leaf[g] = '{data: comp_signed_i ? COMP_MAX_BITS'($signed(w_d)) : COMP_MAX_BITS'(w_d),
                           idx: COMP_MAX_IDX_BITS'(g), live: comp_mask_i[g]};
    end else begin : g_pad
      assign w_leaf[g] = '{data: '0, idx: COMP_MAX_IDX_BITS'(g), live: 1'b0};
    end
  end
  always_comb begin
    w_side[0] = '{valid: comp_valid_i, last: comp_last_i, min: comp_min_i, sgn: comp_signed_i};
    for (int s = 0; s < LEVELS; s++) w_side[s+1] = r_side[s];
  end
  // heap-ordered tree: node k feeds from 2k/2k+1, node 1 is the root
  for (genvar k = 1; k < PAD; k++) begin : g_node
    localparam int S = LEVELS - $clog2(k + 1);
    comp_entry_t w_a, w_b;
    if (2 * k >= PAD) begin : g_from_leaf
      assign w_a = w_leaf[2*k-PAD];
      assign w_b = w_leaf[2*k+1-PAD];
    end else begin : g_from_node
      assign w_a = w_node[2*k];
      assign w_b = w_node[2*k+1];
    end
    ame_num_compare_node u_node (
      .clk_i(clk_i), .rst_i(rst_i), .i_en(w_adv), .i_a(w_a), .i_b(w_b),
      .i_min(w_side[S].min), .i_signed(w_side[S].sgn), .o_q(w_node[k])
    );
  end
  always_comb begin
    w_t = w_node[1];
    w_cur_beat = r_active ? r_cnt : '0;
    w_take = !r_active || comp_better(w_t, r_acc, w_side[LEVELS].min, w_side[LEVELS].sgn);
    w_m = w_take ? w_t : r_acc;
    w_m_beat = w_take ? w_cur_beat : r_acc_beat;
  end
  assign w_unused = ^{w_m.data, w_m.idx};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int s = 0; s < LEVELS; s++) r_side[s] <= '0;
      r_acc <= '0;
      r_acc_beat <= '0;
      r_cnt <= '0;
      r_active <= 1'b0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_idx <= '0;
      r_beat <= '0;
      r_none <= 1'b0;
    end else if (w_adv) begin
      for (int s = 0; s < LEVELS; s++) r_side[s] <= w_side[s];
      r_valid <= w_side[LEVELS].valid && w_side[LEVELS].last;
      if (w_side[LEVELS].valid) begin
        r_active <= !w_side[LEVELS].last;
        r_acc <= w_m;
        r_acc_beat <= w_m_beat;
        r_cnt <= (&w_cur_beat) ? w_cur_beat : w_cur_beat + COMP_BEAT_BITS'(1);
        if (w_side[LEVELS].last) begin
          r_data <= w_m.data[COMP_DATA_BITS-1:0];
          r_idx <= COMP_DATA_IDX_BITS'(w_m.idx);
          r_beat <= w_m_beat;
          r_none <= !w_m.live;
        end
      end
    end
endmodule

// File: doc/ame_num_compare_tree.md
Name: ame_num_compare_tree

Overview:
- Parametrised, pipelined argmax/argmin reduction unit for the AME cost-selection path; successor to the fixed 6-input comparator.
- Reduces COMP_NUM lanes per beat through a registered binary tree, then accumulates across a multi-beat frame.
- Returns the winning value, its lane index and its beat index, with valid/ready backpressure.
- Supports per-beat min/max and signed/unsigned modes plus a lane mask.

Parameters:
- COMP_NUM, 6, number of input lanes per beat (>=2).
- COMP_DATA_BITS, 64, width of each lane value.
- COMP_DATA_IDX_BITS, $clog2(COMP_NUM), lane index width.
- COMP_BEAT_BITS, 4, beat index width within a frame.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- comp_valid_i  in  1  input beat valid.
- comp_ready_o  out  1  input beat accepted when valid&ready.
- comp_last_i  in  1  beat is the last of its frame.
- comp_min_i  in  1  0 = select maximum, 1 = select minimum.
- comp_signed_i  in  1  1 = signed compare, 0 = unsigned.
- comp_mask_i  in  COMP_NUM  1 = lane participates.
- comp_data_i  in  COMP_NUM*COMP_DATA_BITS  lane values, lane 0 in the LSBs.
- comp_valid_o  out  1  frame result valid.
- comp_ready_i  in  1  downstream accepts result.
- comp_data_o  out  COMP_DATA_BITS  winning value.
- comp_data_idx_o  out  COMP_DATA_IDX_BITS  winning lane.
- comp_beat_idx_o  out  COMP_BEAT_BITS  beat holding the winner.
- comp_none_o  out  1  every lane of every beat in the frame was masked.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - all valid flags, accumulator and beat counter cleared;
  - comp_valid_o=0, comp_data_o=0, comp_data_idx_o=0, comp_beat_idx_o=0, comp_none_o=0.
  - comp_ready_o=1 after reset.
- Pipeline advance:
  - adv = !comp_valid_o | comp_ready_i.
  - comp_ready_o = adv.
  - All stages advance together when adv=1 and freeze when adv=0. No beat is dropped or duplicated.
- Tree:
  - LEVELS = $clog2(COMP_NUM). Each level is registered.
  - Lanes are padded to 2^LEVELS with masked entries.
  - Each node carries (value, lane idx, live bit).
  - comp_min_i, comp_signed_i and comp_last_i travel with the beat.
- Node compare rule:
  - A live entry beats a dead one.
  - If both are live, the better value wins. Better means greater for max, lesser for min, compared in the beat's signedness.
  - Ties go to the lower lane index.
  - If both are dead, the result is dead with idx 0.
- Accumulator stage (one register):
  - On the first beat of a frame, load the tree result with beat idx 0.
  - On later beats, replace the held result only if the new result is strictly better, or the held result is dead and the new one is live. Ties keep the earlier beat.
  - The beat counter increments per accepted beat and saturates at all-ones. Frames longer than 2^COMP_BEAT_BITS report a saturated beat index.
  - On a last beat, load the output registers, assert comp_valid_o, and re-arm the accumulator for a new frame.
- Latency: a one-beat frame appears LEVELS+1 cycles after acceptance with no stall. For COMP_NUM=6 that is 4 cycles.
- Throughput: one beat per cycle.
- Output hold: while comp_valid_o=1 and comp_ready_i=0, outputs hold stable.
- On output handshake without a new result: comp_valid_o drops; data, idx and none are held.
- No live lane in a frame: comp_none_o=1, comp_data_o=0, comp_data_idx_o=0, comp_beat_idx_o=0.
- Mode change mid-frame: the mode of the last beat governs the accumulator compare. Mixing modes within a frame is illegal and not checked.
- Reset mid-frame: the partial frame is discarded and no result is emitted.
- Back-to-back frames: a last beat followed by a first beat on consecutive cycles must not merge.

Decomposition:
- Package ame_num_compare_pkg holds:
  - comp_entry_t struct {data, idx, live};
  - function comp_better(a, b, min, signed), shared by tree and accumulator;
  - LEVELS helper.
- One sub-module, ame_num_compare_node: registered 2:1 compare node with enable, instantiated via generate per level/pair.

Test Plan:
1. Single beat, lanes {5,-3,9,9,2,0}, signed max, mask 6'h3F, last=1 -> after 4 cycles: data 9, idx 2, beat 0, none 0.
2. Same data, unsigned min -> data 0, idx 5; with mask 6'h1F -> data 2, idx 4.
3. Three-beat frame, max: beat maxima 7, 12, 12 -> one result: data 12, beat 1. comp_valid_o pulses once, after the third beat only.
4. Hold comp_ready_i=0 for 5 cycles while streaming 4 one-beat frames -> comp_ready_o drops, output stays stable, all 4 results arrive in order with no loss.
5. Frame with all masks 0 over two beats -> comp_none_o=1, data 0, idx 0. The next frame with lane 3 = -1 live gives none 0, idx 3.
6. Assert rst_i mid-frame after beat 1 of 3, then send a fresh one-beat frame -> only the fresh frame's result appears, beat idx 0.
